// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: default operand width, divider
// FSM states and a two's-complement magnitude helper.
package arith_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  // Magnitude of a sign-extended 32-bit value; the most-negative operand of a
  // narrower width maps to 2^(WIDTH-1), which still fits in WIDTH bits.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
//   rem      : partial remainder before the step (always < divisor)
//   dvd_bit  : next dividend bit shifted into the remainder
//   divisor  : |B|
//   rem_next : partial remainder after the step
//   q_bit    : quotient bit produced by the step
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted  = {rem, dvd_bit};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider (restoring, one quotient bit per clock).
//   clk, reset      : rising-edge clock, async active-high reset
//   start           : request, sampled only while idle
//   A, B            : signed dividend / divisor
//   Q, R            : registered signed quotient / remainder (Verilog / and %)
//   busy            : operation in flight
//   done            : one-cycle pulse when Q/R/flags are updated
//   div_by_zero     : held result came from B == 0 (Q = -1, R = A)
//   overflow        : held result came from most-negative / -1 (Q wraps)
module booth_divider
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] absb_q, absb_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic             bzero_q, bzero_d;
  logic             ovfp_q, ovfp_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  assign abs_a = WIDTH'(mag32(32'(signed'(A))));
  assign abs_b = WIDTH'(mag32(32'(signed'(B))));

  // The quotient accumulates in dvd_q as the dividend bits shift out.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (absb_q),
    .rem_next(step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    absb_d  = absb_q;
    a_d     = a_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    bzero_d = bzero_q;
    ovfp_d  = ovfp_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          rem_d   = '0;
          dvd_d   = abs_a;
          absb_d  = abs_b;
          sgnq_d  = A[WIDTH-1] ^ B[WIDTH-1];
          sgnr_d  = A[WIDTH-1];
          bzero_d = (B == '0);
          ovfp_d  = (A == MOST_NEG) && (B == '1);
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = (B == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (bzero_q) begin
          q_d   = '1;
          r_d   = a_q;
          dbz_d = 1'b1;
        end else begin
          // Most-negative / -1 needs no special path: the magnitude
          // quotient truncates to the wrapped value on its own.
          q_d   = sgnq_q ? -dvd_q : dvd_q;
          r_d   = sgnr_q ? -rem_q : rem_q;
          ovf_d = ovfp_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      absb_q  <= '0;
      a_q     <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      bzero_q <= 1'b0;
      ovfp_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      absb_q  <= absb_d;
      a_q     <= a_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      bzero_q <= bzero_d;
      ovfp_q  <= ovfp_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider at WIDTH=4: directed cases, ignored
// start, mid-operation reset and a back-to-back sweep of every (A,B) pair.
module tb_booth_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] A, B, Q, R;
  logic       busy, done, div_by_zero, overflow;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  booth_divider #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .A          (A),
    .B          (B),
    .Q          (Q),
    .R          (R),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = 5;
    if (b == 0) begin
      e.q   = 4'hF;
      e.r   = 4'(a);
      e.dbz = 1'b1;
      e.lat = 1;
    end else if (a == -8 && b == -1) begin
      e.q   = 4'h8;
      e.r   = 4'h0;
      e.ovf = 1'b1;
    end else begin
      e.q = 4'(a / b);
      e.r = 4'(a % b);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drive operands with start high across one edge (the accepting edge).
  task automatic issue(input int a, input int b, input bit hold_start);
    sb.push_back(model(a, b));
    A     = 4'(a);
    B     = 4'(b);
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Count edges until done, checking busy while waiting; then score result.
  task automatic wait_and_score(input int lat0, input string tag);
    int   lat;
    bit   seen;
    exp_t e;
    lat  = lat0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_Q"}, 32'(Q), 32'(e.q));
    chk({tag, "_R"}, 32'(R), 32'(e.r));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
    chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_hold(input string tag);
    logic [3:0] q0, r0;
    q0 = Q;
    r0 = R;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_Q_hold"}, 32'(Q), 32'(q0));
    chk({tag, "_R_hold"}, 32'(R), 32'(r0));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(-7, 3, 1'b0);  wait_and_score(0, "m7_3");   check_hold("m7_3");
    issue(7, -2, 1'b0);  wait_and_score(0, "7_m2");   check_hold("7_m2");
    issue(-8, -8, 1'b0); wait_and_score(0, "m8_m8");  check_hold("m8_m8");
    issue(5, -8, 1'b0);  wait_and_score(0, "5_m8");   check_hold("5_m8");
    issue(-8, -1, 1'b0); wait_and_score(0, "ovf");    check_hold("ovf");
    issue(5, 0, 1'b0);   wait_and_score(0, "dbz");    check_hold("dbz");

    // Second request while busy must be ignored; operands change too.
    issue(6, 4, 1'b0);
    A     = 4'd3;
    B     = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_and_score(1, "ignored_start");
    check_hold("ignored_start");

    // Reset in the middle of CALC: outputs clear at once, no done pulse.
    A     = 4'd3;
    B     = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_Q", 32'(Q), 32'd0);
    chk("midrst_R", 32'(R), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end

    issue(-3, 2, 1'b0);  wait_and_score(0, "after_rst");

    // Back-to-back sweep with start held high.
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        issue(a, b, 1'b1);
        wait_and_score(0, $sformatf("sweep_%0d_%0d", a, b));
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("sweep_idle_busy", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
